// File: rtl/fp_pkg.sv
// Shared types and constants for the FP32 add/sub front end (unpack, swap, align).
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int MANT_W = SIG_W + 3;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
  localparam int BIAS   = 127;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Registered stage-1 contents: classification plus the swapped, unaligned operands.
  typedef struct packed {
    logic              nan;
    logic              invalid;
    logic              inf_a;
    logic              inf_b;
    logic              sign_a;
    logic              sign_b;
    logic              sign_large;
    logic [EXP_W-1:0]  exp_large;
    logic [SIG_W-1:0]  sig_large;
    logic [SIG_W-1:0]  sig_small;
    logic [EXP_W-1:0]  diff;
    logic [2:0]        rm;
  } stage1_t;

  // Output data bundle handed to the normalize stage.
  typedef struct packed {
    logic              nan;
    logic              invalid;
    logic              inf_a;
    logic              inf_b;
    logic              sign_a;
    logic              sign_b;
    logic              sign_large;
    logic              eff_sub;
    logic [EXP_W-1:0]  exp_large;
    logic [MANT_W-1:0] mant_large;
    logic [MANT_W-1:0] mant_small;
    logic [2:0]        rm;
  } align_bundle_t;

  function automatic logic is_nan(fp32_t x);
    return (x.exp == EXP_MAX) && (x.frac != '0);
  endfunction

  function automatic logic is_snan(fp32_t x);
    return is_nan(x) && !x.frac[FRAC_W-1];
  endfunction

  function automatic logic is_inf(fp32_t x);
    return (x.exp == EXP_MAX) && (x.frac == '0);
  endfunction

endpackage

// File: rtl/fp_sticky_shift.sv
// Right shifter for the aligned significand: every bit shifted out is ORed into bit 0,
// and shifts of MANT_W or more collapse to a lone sticky bit.
module fp_sticky_shift
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] din,
  input  logic [EXP_W-1:0]  shamt,
  output logic [MANT_W-1:0] dout
);

  localparam logic [EXP_W-1:0] SAT_SHIFT = EXP_W'(MANT_W);

  logic [MANT_W-1:0] shifted;
  logic [MANT_W-1:0] lost_mask;
  logic              lost;

  always_comb begin
    shifted   = din >> shamt;
    lost_mask = ~({MANT_W{1'b1}} << shamt);
    lost      = |(din & lost_mask);
    if (shamt >= SAT_SHIFT) begin
      dout = {{(MANT_W-1){1'b0}}, |din};
    end else begin
      dout = {shifted[MANT_W-1:1], shifted[0] | lost};
    end
  end

endmodule

// File: rtl/fp_unpack_align.sv
// FP32 add/sub front end: classify, sign-flip, magnitude swap, then sticky alignment,
// as a two-stage valid/ready pipeline. FP_SUBNORMAL_EN keeps subnormals (else DAZ).
module fp_unpack_align
  import fp_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         op_a,
  input  logic [31:0]         op_b,
  input  logic                is_sub,
  input  logic [2:0]          rm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                nan,
  output logic                invalid,
  output logic                inf_a,
  output logic                inf_b,
  output logic                sign_a,
  output logic                sign_b,
  output logic                sign_large,
  output logic                eff_sub,
  output logic [EXP_W-1:0]    exp_large,
  output logic [MANT_W-1:0]   mant_large,
  output logic [MANT_W-1:0]   mant_small,
  output logic [2:0]          rm_out
);

  fp32_t             fa, fb;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic [EXP_W-1:0]  eexp_a, eexp_b;
  logic [SIG_W-1:0]  sig_a, sig_b;
  logic              swap;
  logic              sgn_a, sgn_b;
  stage1_t           s1_new;
  align_bundle_t     s2_new;
  logic [MANT_W-1:0] aligned_small;

  logic              s1_valid_d, s1_valid_q;
  stage1_t           s1_d, s1_q;
  logic              s2_valid_d, s2_valid_q;
  align_bundle_t     s2_d, s2_q;
  logic              s1_adv, s2_adv;

  assign fa = op_a;
  assign fb = op_b;

  // Stage 1: classify, unpack and order operands by magnitude.
  // NOTE: every variable assigned in an always_comb gets a value on every path (defaults
  // first or full if/else), otherwise synthesis infers a latch.
  always_comb begin
`ifdef FP_SUBNORMAL_EN
    frac_a = fa.frac;
    frac_b = fb.frac;
    eexp_a = (fa.exp == '0 && fa.frac != '0) ? EXP_W'(1) : fa.exp;
    eexp_b = (fb.exp == '0 && fb.frac != '0) ? EXP_W'(1) : fb.exp;
`else
    frac_a = (fa.exp == '0) ? '0 : fa.frac;
    frac_b = (fb.exp == '0) ? '0 : fb.frac;
    eexp_a = fa.exp;
    eexp_b = fb.exp;
`endif
    sig_a = {fa.exp != '0, frac_a};
    sig_b = {fb.exp != '0, frac_b};
    sgn_a = fa.sign;
    sgn_b = fb.sign ^ is_sub;
    // Raw {exp, frac} orders subnormals correctly below normals; ties keep A as large.
    swap  = {fb.exp, frac_b} > {fa.exp, frac_a};

    s1_new            = '0;
    s1_new.nan        = is_nan(fa) || is_nan(fb);
    s1_new.invalid    = is_snan(fa) || is_snan(fb);
    s1_new.inf_a      = is_inf(fa);
    s1_new.inf_b      = is_inf(fb);
    s1_new.sign_a     = sgn_a;
    s1_new.sign_b     = sgn_b;
    s1_new.sign_large = swap ? sgn_b : sgn_a;
    s1_new.exp_large  = swap ? eexp_b : eexp_a;
    s1_new.sig_large  = swap ? sig_b : sig_a;
    s1_new.sig_small  = swap ? sig_a : sig_b;
    s1_new.diff       = swap ? (eexp_b - eexp_a) : (eexp_a - eexp_b);
    s1_new.rm         = rm;
  end

  fp_sticky_shift u_align (
    .din   ({s1_q.sig_small, 3'b000}),
    .shamt (s1_q.diff),
    .dout  (aligned_small)
  );

  always_comb begin
    s2_new            = '0;
    s2_new.nan        = s1_q.nan;
    s2_new.invalid    = s1_q.invalid;
    s2_new.inf_a      = s1_q.inf_a;
    s2_new.inf_b      = s1_q.inf_b;
    s2_new.sign_a     = s1_q.sign_a;
    s2_new.sign_b     = s1_q.sign_b;
    s2_new.sign_large = s1_q.sign_large;
    s2_new.eff_sub    = s1_q.sign_a ^ s1_q.sign_b;
    s2_new.exp_large  = s1_q.exp_large;
    s2_new.mant_large = {s1_q.sig_large, 3'b000};
    s2_new.mant_small = aligned_small;
    s2_new.rm         = s1_q.rm;
  end

  // Handshake: a stage moves when it is empty or its consumer is moving.
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s1_d       = (s1_adv && in_valid) ? s1_new : s1_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_d       = (s2_adv && s1_valid_q) ? s2_new : s2_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: data registers are reset too, since the output bundle must read zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
    end
  end

  assign in_ready   = s1_adv;
  assign out_valid  = s2_valid_q;
  assign nan        = s2_q.nan;
  assign invalid    = s2_q.invalid;
  assign inf_a      = s2_q.inf_a;
  assign inf_b      = s2_q.inf_b;
  assign sign_a     = s2_q.sign_a;
  assign sign_b     = s2_q.sign_b;
  assign sign_large = s2_q.sign_large;
  assign eff_sub    = s2_q.eff_sub;
  assign exp_large  = s2_q.exp_large;
  assign mant_large = s2_q.mant_large;
  assign mant_small = s2_q.mant_small;
  assign rm_out     = s2_q.rm;

endmodule

// File: tb/tb_fp_unpack_align.sv
// Self-checking bench for fp_unpack_align: directed vectors, backpressure, reset and
// randomized traffic scored against an arithmetic reference model (honours FP_SUBNORMAL_EN).
module tb_fp_unpack_align;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] op_a, op_b;
  logic        is_sub;
  logic [2:0]  rm, rm_out;
  logic        nan, invalid, inf_a, inf_b, sign_a, sign_b, sign_large, eff_sub;
  logic [7:0]  exp_large;
  logic [26:0] mant_large, mant_small;

  int errors = 0;
  int checks = 0;
  int out_count = 0;
  align_bundle_t sb[$];
  align_bundle_t obs;

  fp_unpack_align dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .is_sub(is_sub), .rm(rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .nan(nan), .invalid(invalid), .inf_a(inf_a), .inf_b(inf_b),
    .sign_a(sign_a), .sign_b(sign_b), .sign_large(sign_large), .eff_sub(eff_sub),
    .exp_large(exp_large), .mant_large(mant_large), .mant_small(mant_small), .rm_out(rm_out)
  );

  always #5 clk = ~clk;

  assign obs = {nan, invalid, inf_a, inf_b, sign_a, sign_b, sign_large, eff_sub,
                exp_large, mant_large, mant_small, rm_out};

  // Reference: value-level semantics with integer arithmetic.
  function automatic align_bundle_t model(logic [31:0] a, logic [31:0] b, logic sub, logic [2:0] r);
    align_bundle_t m;
    longint ea, eb, fa, fb, xa, xb, siga, sigb, sigl, sigs, xl, xs, diff, ext, p, q;
    logic   sa, sb_s, swp;
    ea = longint'(a[30:23]); fa = longint'(a[22:0]);
    eb = longint'(b[30:23]); fb = longint'(b[22:0]);
    m = '0;
    m.nan     = (ea == 255 && fa != 0) || (eb == 255 && fb != 0);
    m.invalid = (ea == 255 && fa != 0 && fa < 64'h400000) || (eb == 255 && fb != 0 && fb < 64'h400000);
    m.inf_a   = (ea == 255 && fa == 0);
    m.inf_b   = (eb == 255 && fb == 0);
    sa   = a[31];
    sb_s = b[31] ^ sub;
`ifdef FP_SUBNORMAL_EN
    xa = (ea == 0 && fa != 0) ? 1 : ea;
    xb = (eb == 0 && fb != 0) ? 1 : eb;
`else
    if (ea == 0) fa = 0;
    if (eb == 0) fb = 0;
    xa = ea;
    xb = eb;
`endif
    siga = (ea != 0 ? 64'h800000 : 0) + fa;
    sigb = (eb != 0 ? 64'h800000 : 0) + fb;
    swp  = (eb * 64'h800000 + fb) > (ea * 64'h800000 + fa);
    sigl = swp ? sigb : siga;  sigs = swp ? siga : sigb;
    xl   = swp ? xb : xa;      xs   = swp ? xa : xb;
    diff = xl - xs;
    if (diff >= 27) begin
      q = (sigs != 0) ? 1 : 0;
    end else begin
      ext = sigs * 8;
      p   = 64'd1 << diff;
      q   = ext / p;
      if (ext % p != 0) q = q | 1;
    end
    m.sign_a     = sa;
    m.sign_b     = sb_s;
    m.sign_large = swp ? sb_s : sa;
    m.eff_sub    = sa ^ sb_s;
    m.exp_large  = 8'(xl);
    m.mant_large = 27'(sigl * 8);
    m.mant_small = 27'(q);
    m.rm         = r;
    return m;
  endfunction

  // Scoreboard: predict on accept, compare on every output transfer, in order.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        checks++;
        out_count++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got output %h with nothing outstanding", obs);
        end else begin
          align_bundle_t e;
          e = sb.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL sb_data: got %h expected %h", obs, e);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(op_a, op_b, is_sub, rm));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All driving tasks start and end just after a rising edge.
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic [2:0] r);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; op_a = a; op_b = b; is_sub = sub; rm = r;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: op %h/%h never accepted", a, b);
    end
  endtask

  task automatic wait_out(output align_bundle_t got);
    logic seen;
    seen = 1'b0;
    got  = '0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        got  = obs;
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL output_timeout: no out_valid within bound");
    end
  endtask

  // Checks out_valid is low one edge after acceptance and high after the second.
  task automatic get_with_latency(input string tag, output align_bundle_t got);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_latency_early: out_valid=%b expected 0", tag, out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s_latency: out_valid=%b expected 1", tag, out_valid);
    end
    got = obs;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; is_sub = 1'b0; rm = '0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || obs !== '0) begin
      errors++; $display("FAIL reset_outputs: out_valid=%b data=%h expected 0/0", out_valid, obs);
    end
    #9 reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic;
    align_bundle_t g;
    out_ready = 1'b1;
    drive_op(32'h3F800000, 32'h3FC00000, 1'b0, 3'd3);
    get_with_latency("basic", g);
    checks++;
    if (g.exp_large !== 8'd127 || g.mant_large !== 27'h6000000 || g.mant_small !== 27'h4000000 ||
        g.sign_large !== 1'b0 || g.eff_sub !== 1'b0 || g.rm !== 3'd3) begin
      errors++; $display("FAIL basic_1p0_1p5: got exp=%0d ml=%h ms=%h sl=%b es=%b rm=%0d expected 127/6000000/4000000/0/0/3",
                         g.exp_large, g.mant_large, g.mant_small, g.sign_large, g.eff_sub, g.rm);
    end
  endtask

  task automatic test_align;
    align_bundle_t g;
    drive_op(32'h3F800000, 32'h33800000, 1'b0, 3'd0);
    wait_out(g);
    checks++;
    if (g.mant_small !== 27'h0000004) begin
      errors++; $display("FAIL align_diff24: mant_small=%h expected 0000004", g.mant_small);
    end
    drive_op(32'h3F800000, 32'h2F800000, 1'b0, 3'd0);
    wait_out(g);
    checks++;
    if (g.mant_small !== 27'h0000001) begin
      errors++; $display("FAIL align_diff32: mant_small=%h expected 0000001", g.mant_small);
    end
    drive_op(32'hBF800000, 32'h3F400000, 1'b1, 3'd1);  // -1.0 - 0.75, diff 1
    wait_out(g);
    checks++;
    if (g.mant_small !== 27'h3000000 || g.sign_large !== 1'b1 || g.eff_sub !== 1'b0) begin
      errors++; $display("FAIL align_diff1: ms=%h sl=%b es=%b expected 3000000/1/0", g.mant_small, g.sign_large, g.eff_sub);
    end
  endtask

  task automatic test_special;
    align_bundle_t g;
    drive_op(32'h7F800001, 32'h3F800000, 1'b0, 3'd0);
    wait_out(g);
    checks++;
    if (g.nan !== 1'b1 || g.invalid !== 1'b1) begin
      errors++; $display("FAIL snan: nan=%b invalid=%b expected 1/1", g.nan, g.invalid);
    end
    drive_op(32'h3F800000, 32'h7FC00000, 1'b0, 3'd0);
    wait_out(g);
    checks++;
    if (g.nan !== 1'b1 || g.invalid !== 1'b0) begin
      errors++; $display("FAIL qnan: nan=%b invalid=%b expected 1/0", g.nan, g.invalid);
    end
    drive_op(32'h7F800000, 32'h7F800000, 1'b1, 3'd0);
    wait_out(g);
    checks++;
    if (g.inf_a !== 1'b1 || g.inf_b !== 1'b1 || g.sign_a !== 1'b0 || g.sign_b !== 1'b1 ||
        g.eff_sub !== 1'b1 || g.nan !== 1'b0) begin
      errors++; $display("FAIL inf_sub_inf: ia=%b ib=%b sa=%b sb=%b es=%b nan=%b expected 1/1/0/1/1/0",
                         g.inf_a, g.inf_b, g.sign_a, g.sign_b, g.eff_sub, g.nan);
    end
    drive_op(32'h80000000, 32'h00000000, 1'b0, 3'd0);
    wait_out(g);
    checks++;
    if (g.mant_large !== '0 || g.mant_small !== '0 || g.exp_large !== 8'd0 || g.sign_large !== 1'b1) begin
      errors++; $display("FAIL both_zero: ml=%h ms=%h exp=%0d sl=%b expected 0/0/0/1",
                         g.mant_large, g.mant_small, g.exp_large, g.sign_large);
    end
  endtask

  task automatic test_subnormal;
    align_bundle_t g;
    logic [26:0] exp_ms;
`ifdef FP_SUBNORMAL_EN
    exp_ms = 27'h0000008;
`else
    exp_ms = 27'h0000000;
`endif
    drive_op(32'h00000001, 32'h00800000, 1'b0, 3'd0);
    wait_out(g);
    checks++;
    if (g.mant_small !== exp_ms || g.exp_large !== 8'd1 || g.mant_large !== 27'h4000000) begin
      errors++; $display("FAIL subnormal: ms=%h exp=%0d ml=%h expected %h/1/4000000",
                         g.mant_small, g.exp_large, g.mant_large, exp_ms);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0]   va[4];
    logic [31:0]   vb[4];
    int            acc, base;
    logic          hs, have_snap;
    align_bundle_t snap;
    va = '{32'h40000000, 32'h41200000, 32'hC0400000, 32'h3E800000};
    vb = '{32'h3F800000, 32'h40A00000, 32'h42C80000, 32'hBF000000};
    acc = 0; have_snap = 1'b0; snap = '0;
    base = out_count;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (acc < 4); op_a = va[acc % 4]; op_b = vb[acc % 4]; is_sub = acc[0]; rm = 3'(acc);
      @(negedge clk);
      if (out_valid) begin
        if (have_snap) begin
          checks++;
          if (obs !== snap) begin
            errors++; $display("FAIL bp_stable: got %h expected %h", obs, snap);
          end
        end else begin
          snap = obs; have_snap = 1'b1;
        end
      end
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) acc++;
    end
    checks++;
    if (acc != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_stall: accepts=%0d in_ready=%b out_valid=%b expected 2/0/1", acc, in_ready, out_valid);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 50 && acc < 4; c++) begin
      in_valid = 1'b1; op_a = va[acc]; op_b = vb[acc]; is_sub = acc[0]; rm = 3'(acc);
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
      if (hs) acc++;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 50 && sb.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (out_count - base != 4 || sb.size() != 0) begin
      errors++; $display("FAIL bp_drain: emitted=%0d pending=%0d expected 4/0", out_count - base, sb.size());
    end
  endtask

  task automatic test_reset_midflight;
    align_bundle_t g;
    out_ready = 1'b0;
    drive_op(32'h40400000, 32'h3F800000, 1'b0, 3'd0);
    drive_op(32'h40800000, 32'h40000000, 1'b1, 3'd0);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || obs !== '0) begin
      errors++; $display("FAIL midflight_reset: out_valid=%b data=%h expected 0/0", out_valid, obs);
    end
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_op(32'h41000000, 32'h3F800000, 1'b0, 3'd4);
    get_with_latency("post_reset", g);
    checks++;
    if (g.exp_large !== 8'd130 || g.mant_small !== 27'h0800000 || g.rm !== 3'd4) begin
      errors++; $display("FAIL post_reset_data: exp=%0d ms=%h rm=%0d expected 130/0800000/4", g.exp_large, g.mant_small, g.rm);
    end
  endtask

  function automatic logic [31:0] gen_fp(logic [7:0] near_exp);
    logic [31:0] v;
    logic [7:0]  e;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:0] = '0;
      1: begin v[30:23] = 8'd255; v[22:0] = '0; end
      2: v[30:23] = 8'd255;
      3: v[30:23] = 8'd0;
      4: begin
           e = 8'(near_exp + 8'($urandom_range(0, 6)));
           v[30:23] = (e == 8'd255 || e == 8'd0) ? 8'd100 : e;
         end
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    if ($urandom_range(0, 3) == 0 && v[30:23] != 8'd255) v[22:0] = 23'($urandom_range(0, 7));
    return v;
  endfunction

  task automatic test_random;
    int   sent, base;
    logic pending, hs;
    sent = 0; pending = 1'b0;
    base = out_count;
    for (int c = 0; c < 3000 && sent < 400; c++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        op_a = gen_fp(8'($urandom_range(90, 160)));
        op_b = ($urandom_range(0, 1) == 1) ? gen_fp(op_a[30:23]) : gen_fp(8'($urandom_range(90, 160)));
        is_sub = 1'($urandom); rm = 3'($urandom);
        pending = 1'b1;
      end
      in_valid  = pending;
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin pending = 1'b0; sent++; end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 50 && sb.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (out_count - base != sent || sent != 400) begin
      errors++; $display("FAIL random_count: emitted=%0d accepted=%0d expected 400 each", out_count - base, sent);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_align();
    test_special();
    test_subnormal();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_unpack_align.md
Name: fp_unpack_align

Overview:
- Front-end stage of the FP32 add/sub datapath; feeds the existing normalize and round stages.
- Unpacks two operands, classifies special values, applies the subtract sign flip, and swaps operands by magnitude.
- Aligns the smaller significand into a 27-bit {hidden, frac[22:0], G, R, S} field with sticky collection.
- Two-stage valid/ready pipeline with full backpressure.

Parameters:
- MANT_W, 27, aligned significand width: 1 hidden + 23 fraction + G, R, S.
- EXP_W, 8, exponent width; fixed for FP32, exposed for the package.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  stage can accept.
- op_a  in  32  FP32 operand A.
- op_b  in  32  FP32 operand B.
- is_sub  in  1  1 = A - B.
- rm  in  3  rounding mode, passed through.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  downstream accepts.
- nan  out  1  either operand is NaN.
- invalid  out  1  either operand is a signaling NaN (exp 255, frac != 0, frac[22] = 0).
- inf_a, inf_b  out  1 each  operand is infinity.
- sign_a, sign_b  out  1 each  sign_a = op_a[31]; sign_b = op_b[31] ^ is_sub.
- sign_large  out  1  sign of the larger-magnitude operand (with the flip applied).
- eff_sub  out  1  sign_a ^ sign_b.
- exp_large  out  8  biased exponent of the larger operand.
- mant_large  out  27  larger significand, GRS = 0.
- mant_small  out  27  aligned smaller significand with GRS.
- rm_out  out  3  registered rm.

Behaviour:
- Reset (asynchronous, immediate): both stage-valid flags clear; out_valid = 0; all data outputs = 0; in_ready = 1 after release.
- Latency: 2 cycles from in_valid && in_ready to out_valid, with out_ready held high. Throughput: 1 per cycle.
- Handshakes:
  - Stage 2 advances when !s2_valid || out_ready.
  - Stage 1 advances when !s1_valid || stage 2 advances.
  - in_ready = stage-1 advance condition. Combinational path from out_ready to in_ready is accepted.
  - Outputs hold stable while out_valid && !out_ready.
  - Order is preserved; no drop or duplication under any in_valid/out_ready pattern.
- Stage 1 (classify and swap):
  - Zero: exp == 0 and frac == 0. Hidden bit = 1 when exp != 0.
  - Magnitude compare on {exp, frac}. If B > A, swap. Ties keep A as large.
  - diff = exp_large - exp_small, 8-bit unsigned, never negative after the swap.
  - Register flags, signs, both 24-bit significands, diff, and rm.
- Stage 2 (align):
  - mant_large = {sig_large, 3'b000}.
  - If diff >= 27: mant_small = {26'b0, |sig_small}.
  - Otherwise: mant_small = ({sig_small, 3'b000} >> diff), with bit 0 ORed with every bit shifted out.
- Special values: significands are still computed as above; downstream resolves priority. The inf - inf to NaN case is produced downstream from inf_a, inf_b, sign_a, sign_b.
- Both zero: mant_large = mant_small = 0, exp_large = 0, sign_large = sign_a.

Optional Feature:
- Macro: FP_SUBNORMAL_EN.
- Defined: a subnormal operand (exp 0, frac != 0) uses hidden bit 0 and effective exponent 1 for the compare and diff.
- Undefined: subnormal inputs are flushed to signed zero (DAZ) before the compare.

Decomposition:
- Package fp_pkg:
  - constants EXP_W, FRAC_W = 23, MANT_W, EXP_MAX = 8'd255, BIAS = 127;
  - typedef fp32_t (packed sign/exp/frac);
  - typedef align_bundle_t (the output data fields);
  - function is_snan.
- One natural sub-module: fp_sticky_shift (27-bit right shifter with sticky OR and saturation at shift >= 27), instantiated in stage 2.

Test Plan:
- 0x3F800000 + 0x3FC00000, out_ready = 1 → after 2 cycles: exp_large = 127, mant_large = 27'h6000000, mant_small = 27'h4000000, sign_large = 0, eff_sub = 0.
- 0x3F800000 + 0x33800000 (diff 24) → mant_small = 27'h0000004 (G only); 0x3F800000 + 0x2F800000 (diff 32) → mant_small = 27'h0000001 (sticky only).
- 0x7F800001 + 0x3F800000 → nan = 1, invalid = 1. 0x7F800000 - 0x7F800000 (is_sub = 1) → inf_a = inf_b = 1, sign_a = 0, sign_b = 1, eff_sub = 1.
- Backpressure: issue 4 back-to-back ops with out_ready = 0 for 6 cycles → in_ready falls after 2 accepts; outputs stable; the 4 ops emerge in order once out_ready = 1.
- Subnormal 0x00000001 + 0x00800000:
  - with FP_SUBNORMAL_EN: mant_small = 27'h0000008, exp_large = 1;
  - without: small operand treated as zero, mant_small = 0.
- Reset: drop reset_n with both stages valid → out_valid = 0 immediately (no clock); after release, the first new op emerges 2 cycles after acceptance.
